fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit_pc_register.sv | 43 ++++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor package for the fetch path.
// Holds the PC/instruction widths, the reset fetch address and the
// fetch FSM state encoding used by fetch_unit.
package fetch_unit_pkg;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned INSTR_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_register.sv
// pc_register: fetch program counter with load, increment and natural
// wrap-around at the top of the address space.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, loads RESET_PC
//   load_i     - load load_val_i (takes priority over inc_i)
//   load_val_i - value to load
//   inc_i      - advance to the next address (8'hFF wraps to 8'h00)
//   pc_o       - current fetch address
module pc_register
  import fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [PC_WIDTH-1:0] load_val_i,
  input  logic                inc_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction byte at a time from instruction
// memory and presents it to the control unit, with stall and
// branch/jump redirect handling. All outputs are registers.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   imem_req/addr     - memory read request and address (held until ack)
//   imem_ack/rdata    - memory response valid and returned byte
//   stall             - control unit cannot take the presented instruction
//   redirect_en/target- taken jump/branch and its new fetch address
//   instruction       - registered instruction byte (opcode in [7:4])
//   instr_valid       - instruction holds a live instruction
//   pc                - address the presented instruction came from
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect_en,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc
);

  fetch_state_e          state_q, state_d;
  logic                  req_q, req_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   tgt_q, tgt_d;

  logic                  fpc_load;
  logic [PC_WIDTH-1:0]   fpc_load_val;
  logic                  fpc_inc;
  logic [PC_WIDTH-1:0]   fetch_pc;

  pc_register u_pc_register (
    .clk        (clk),
    .rst        (rst),
    .load_i     (fpc_load),
    .load_val_i (fpc_load_val),
    .inc_i      (fpc_inc),
    .pc_o       (fetch_pc)
  );

  // Whenever a new fetch address is chosen, the request address register
  // is loaded with the same value in the same cycle, so FETCH always
  // presents imem_addr == fetch_pc without an extra bubble.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    fpc_load     = 1'b0;
    fpc_load_val = fetch_pc;
    fpc_inc      = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!req_q) begin
          // No request outstanding (only right after reset): issue one.
          // Any ack seen here belongs to an abandoned request.
          req_d = 1'b1;
          if (redirect_en) begin
            fpc_load     = 1'b1;
            fpc_load_val = redirect_target;
            addr_d       = redirect_target;
          end else begin
            addr_d = fetch_pc;
          end
        end else if (redirect_en) begin
          if (imem_ack) begin
            // Response arrives with the redirect: drop it, refetch at target.
            fpc_load     = 1'b1;
            fpc_load_val = redirect_target;
            addr_d       = redirect_target;
          end else begin
            tgt_d   = redirect_target;
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc;
          valid_d = 1'b1;
          fpc_inc = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (redirect_en) begin
          valid_d      = 1'b0;
          fpc_load     = 1'b1;
          fpc_load_val = redirect_target;
          req_d        = 1'b1;
          addr_d       = redirect_target;
          state_d      = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = fetch_pc;
          state_d = FETCH;
        end
      end

      DISCARD: begin
        if (imem_ack) begin
          // A redirect on the ack cycle is newer than the latched target.
          fpc_load     = 1'b1;
          fpc_load_val = redirect_en ? redirect_target : tgt_q;
          addr_d       = fpc_load_val;
          req_d        = 1'b1;
          state_d      = FETCH;
        end else if (redirect_en) begin
          tgt_d = redirect_target;
        end
      end

      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

endmodule
